// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter in front of a 2:1 select mux: grants bursts of up to
// BURST beats per source and drives the mux select plus a registered output beat.
module mux_sel_arbiter #(
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [WIDTH-1:0]             d0_data,
  input  logic                         d0_valid,
  output logic                         d0_ready,
  input  logic [WIDTH-1:0]             d1_data,
  input  logic                         d1_valid,
  output logic                         d1_ready,
  output logic [WIDTH-1:0]             y_data,
  output logic                         y_valid,
  input  logic                         y_ready,
  output logic                         sel,
  output logic                         busy,
  output logic [1:0]                   dbg_state,
  output logic [$clog2(BURST+1)-1:0]   dbg_cnt
);

  localparam int CW = $clog2(BURST + 1);
  localparam logic [CW-1:0] BURST_C = CW'(BURST);

  // Handshake: a beat moves on any channel in a cycle where valid and ready
  // are both high at the rising edge; ready never depends on the same
  // channel's valid, and valid must not wait for ready.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  y_data_q, y_data_d;
  logic              y_valid_q, y_valid_d;

  logic              space;
  logic              acc0, acc1;
  logic              cur_acc, cur_valid, oth_valid;
  state_e            oth_state;
  logic [CW-1:0]     cnt_inc;

  always_comb begin
    space    = ~y_valid_q | y_ready;
    d0_ready = (state_q == GRANT0) & space;
    d1_ready = (state_q == GRANT1) & space;
    acc0     = d0_valid & d0_ready;
    acc1     = d1_valid & d1_ready;

    y_data_d  = y_data_q;
    y_valid_d = y_valid_q;
    if (acc0) begin
      y_data_d  = d0_data;
      y_valid_d = 1'b1;
    end else if (acc1) begin
      y_data_d  = d1_data;
      y_valid_d = 1'b1;
    end else if (y_ready) begin
      y_valid_d = 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    cur_acc   = acc0 | acc1;
    cur_valid = (state_q == GRANT1) ? d1_valid : d0_valid;
    oth_valid = (state_q == GRANT1) ? d0_valid : d1_valid;
    oth_state = (state_q == GRANT1) ? GRANT0 : GRANT1;
    cnt_inc   = cnt_q + CW'(1);

    unique case (state_q)
      IDLE: begin
        // last holds the most recent grant, so a tie goes to the other source
        if (d0_valid & d1_valid) begin
          state_d = last_q ? GRANT0 : GRANT1;
          last_d  = ~last_q;
          cnt_d   = '0;
        end else if (d0_valid) begin
          state_d = GRANT0;
          last_d  = 1'b0;
          cnt_d   = '0;
        end else if (d1_valid) begin
          state_d = GRANT1;
          last_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      GRANT0, GRANT1: begin
        if (cur_acc) begin
          if (cnt_inc == BURST_C) begin
            cnt_d = '0;
            if (oth_valid) begin
              state_d = oth_state;
              last_d  = (oth_state == GRANT1);
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end else if (!cur_valid) begin
          cnt_d = '0;
          if (oth_valid) begin
            state_d = oth_state;
            last_d  = (oth_state == GRANT1);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      cnt_q     <= '0;
      y_data_q  <= '0;
      y_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      y_data_q  <= y_data_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign y_data    = y_data_q;
  assign y_valid   = y_valid_q;
  assign sel       = (state_q == GRANT1);
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;
  assign dbg_cnt   = cnt_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed bench for mux_sel_arbiter: one task per scenario, hand-computed
// expectations checked inline, one summary line at the end.
module tb_mux_sel_arbiter;

  localparam int WIDTH = 8;
  localparam int BURST = 4;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] d0_data, d1_data;
  logic             d0_valid, d1_valid;
  logic             d0_ready, d1_ready;
  logic [WIDTH-1:0] y_data;
  logic             y_valid, y_ready;
  logic             sel, busy;
  logic [1:0]       dbg_state;
  logic [2:0]       dbg_cnt;

  int errors = 0;
  int checks = 0;

  mux_sel_arbiter #(.WIDTH(WIDTH), .BURST(BURST)) dut (
    .clk(clk), .rst_n(rst_n),
    .d0_data(d0_data), .d0_valid(d0_valid), .d0_ready(d0_ready),
    .d1_data(d1_data), .d1_valid(d1_valid), .d1_ready(d1_ready),
    .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready),
    .sel(sel), .busy(busy), .dbg_state(dbg_state), .dbg_cnt(dbg_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: sources advance their data after a beat they offered was taken.
  task automatic tick();
    logic a0, a1;
    a0 = d0_valid & d0_ready;
    a1 = d1_valid & d1_ready;
    @(posedge clk);
    #1;
    if (a0) d0_data = d0_data + 8'd1;
    if (a1) d1_data = d1_data + 8'd1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; d0_valid = 1'b1; d1_valid = 1'b1; y_ready = 1'b1;
    d0_data = 8'h00; d1_data = 8'h00;
    tick(); tick();
    checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL rst_y_valid got=%0b exp=0", y_valid); end
    checks++; if (sel !== 1'b0) begin errors++; $display("FAIL rst_sel got=%0b exp=0", sel); end
    checks++; if ({d0_ready, d1_ready} !== 2'b00) begin errors++; $display("FAIL rst_ready got=%b exp=00", {d0_ready, d1_ready}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%0b exp=0", busy); end
    checks++; if (y_data !== 8'h00) begin errors++; $display("FAIL rst_y_data got=%h exp=00", y_data); end
    d0_valid = 1'b0; d1_valid = 1'b0; rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_source();
    d1_data = 8'h10; d1_valid = 1'b1; d0_valid = 1'b0; y_ready = 1'b1;
    #1;
    checks++; if (d1_ready !== 1'b0) begin errors++; $display("FAIL t2_idle_ready got=%0b exp=0", d1_ready); end
    tick();
    checks++; if (sel !== 1'b1) begin errors++; $display("FAIL t2_sel got=%0b exp=1", sel); end
    checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL t2_first_y_valid got=%0b exp=0", y_valid); end
    for (int i = 0; i < 8; i++) begin
      checks++; if ({d0_ready, d1_ready} !== 2'b01) begin errors++; $display("FAIL t2_ready beat=%0d got=%b exp=01", i, {d0_ready, d1_ready}); end
      tick();
      d1_valid = (d1_data <= 8'h17);
      checks++; if (y_valid !== 1'b1 || y_data !== 8'h10 + 8'(i)) begin errors++; $display("FAIL t2_data beat=%0d got=%0b/%h exp=1/%h", i, y_valid, y_data, 8'h10 + 8'(i)); end
    end
    tick();
    checks++; if ({busy, sel, y_valid} !== 3'b000) begin errors++; $display("FAIL t2_idle got=%b exp=000", {busy, sel, y_valid}); end
  endtask

  task automatic test_contention();
    logic [WIDTH-1:0] exp_d;
    int src;
    d0_data = 8'hA0; d1_data = 8'hB0; d0_valid = 1'b1; d1_valid = 1'b1; y_ready = 1'b1;
    tick();
    for (int k = 0; k < 12; k++) begin
      src = (k / BURST) % 2;
      exp_d = (src == 0) ? 8'hA0 + 8'((k / 8) * 4 + k % 4) : 8'hB0 + 8'(k % 4);
      checks++; if (sel !== src[0]) begin errors++; $display("FAIL t3_sel beat=%0d got=%0b exp=%0d", k, sel, src); end
      checks++; if ({d1_ready, d0_ready} !== ((src == 0) ? 2'b01 : 2'b10)) begin errors++; $display("FAIL t3_ready beat=%0d got=%b src=%0d", k, {d1_ready, d0_ready}, src); end
      tick();
      checks++; if (y_valid !== 1'b1 || y_data !== exp_d) begin errors++; $display("FAIL t3_data beat=%0d got=%0b/%h exp=1/%h", k, y_valid, y_data, exp_d); end
    end
    checks++; if (sel !== 1'b1) begin errors++; $display("FAIL t3_final_sel got=%0b exp=1", sel); end
    d0_valid = 1'b0; d1_valid = 1'b0;
    tick();
    checks++; if ({busy, y_valid} !== 2'b00) begin errors++; $display("FAIL t3_idle got=%b exp=00", {busy, y_valid}); end
  endtask

  task automatic test_backpressure();
    d0_data = 8'h40; d0_valid = 1'b1; d1_valid = 1'b0; y_ready = 1'b1;
    tick();
    checks++; if ({sel, d0_ready, busy} !== 3'b011) begin errors++; $display("FAIL t4_grant got=%b exp=011", {sel, d0_ready, busy}); end
    tick();
    checks++; if (y_data !== 8'h40 || dbg_cnt !== 3'd1) begin errors++; $display("FAIL t4_beat0 got=%h/%0d exp=40/1", y_data, dbg_cnt); end
    tick();
    checks++; if (y_data !== 8'h41 || dbg_cnt !== 3'd2) begin errors++; $display("FAIL t4_beat1 got=%h/%0d exp=41/2", y_data, dbg_cnt); end
    y_ready = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (d0_ready !== 1'b0) begin errors++; $display("FAIL t4_stall_ready cyc=%0d got=%0b exp=0", i, d0_ready); end
      checks++; if (y_valid !== 1'b1 || y_data !== 8'h41) begin errors++; $display("FAIL t4_stall_data cyc=%0d got=%0b/%h exp=1/41", i, y_valid, y_data); end
      checks++; if (dbg_cnt !== 3'd2 || dbg_state !== 2'd1) begin errors++; $display("FAIL t4_stall_cnt cyc=%0d got=%0d/%0d exp=2/1", i, dbg_cnt, dbg_state); end
      tick();
    end
    y_ready = 1'b1;
    #1;
    checks++; if (d0_ready !== 1'b1) begin errors++; $display("FAIL t4_resume_ready got=%0b exp=1", d0_ready); end
    tick();
    checks++; if (y_data !== 8'h42 || dbg_cnt !== 3'd3) begin errors++; $display("FAIL t4_beat2 got=%h/%0d exp=42/3", y_data, dbg_cnt); end
    tick();
    checks++; if (y_data !== 8'h43 || dbg_cnt !== 3'd0 || dbg_state !== 2'd1) begin errors++; $display("FAIL t4_beat3 got=%h/%0d/%0d exp=43/0/1", y_data, dbg_cnt, dbg_state); end
    d0_valid = 1'b0;
    tick();
    checks++; if ({busy, y_valid} !== 2'b00) begin errors++; $display("FAIL t4_idle got=%b exp=00", {busy, y_valid}); end
  endtask

  task automatic test_source_drop();
    d0_data = 8'h60; d0_valid = 1'b1; d1_valid = 1'b0; y_ready = 1'b1;
    tick();
    d1_data = 8'h70; d1_valid = 1'b1;
    tick();
    tick();
    d0_valid = 1'b0;
    #1;
    checks++; if ({sel, d0_ready, d1_ready} !== 3'b010) begin errors++; $display("FAIL t5_before got=%b exp=010", {sel, d0_ready, d1_ready}); end
    checks++; if (y_data !== 8'h61) begin errors++; $display("FAIL t5_last_data got=%h exp=61", y_data); end
    tick();
    checks++; if ({sel, d1_ready, y_valid} !== 3'b110) begin errors++; $display("FAIL t5_switch got=%b exp=110", {sel, d1_ready, y_valid}); end
    d1_valid = 1'b0;
    tick();
    checks++; if ({busy, sel} !== 2'b00) begin errors++; $display("FAIL t5_idle1 got=%b exp=00", {busy, sel}); end
    d0_data = 8'h68; d0_valid = 1'b1;
    tick();
    tick();
    d0_valid = 1'b0;
    tick();
    checks++; if ({busy, sel, y_data} !== {2'b00, 8'h68}) begin errors++; $display("FAIL t5_idle2 got=%b/%h exp=00/68", {busy, sel}, y_data); end
  endtask

  task automatic test_reset_mid_burst();
    d1_data = 8'h80; d1_valid = 1'b1; d0_valid = 1'b0; y_ready = 1'b1;
    tick();
    tick();
    d0_data = 8'h90; d0_valid = 1'b1; rst_n = 1'b0;
    #1;
    checks++; if ({sel, y_valid, y_data} !== {2'b11, 8'h80}) begin errors++; $display("FAIL t6_pre got=%b/%h exp=11/80", {sel, y_valid}, y_data); end
    tick();
    checks++; if ({y_valid, busy, sel} !== 3'b000 || dbg_state !== 2'd0 || y_data !== 8'h00) begin errors++; $display("FAIL t6_reset got=%b/%0d/%h exp=000/0/00", {y_valid, busy, sel}, dbg_state, y_data); end
    rst_n = 1'b1;
    tick();
    checks++; if ({sel, busy, d0_ready, d1_ready} !== 4'b0110) begin errors++; $display("FAIL t6_first_grant got=%b exp=0110", {sel, busy, d0_ready, d1_ready}); end
    tick();
    checks++; if (y_valid !== 1'b1 || y_data !== 8'h90) begin errors++; $display("FAIL t6_data got=%0b/%h exp=1/90", y_valid, y_data); end
    d0_valid = 1'b0; d1_valid = 1'b0;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_single_source();
    test_contention();
    test_backpressure();
    test_source_drop();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
